// File: rtl/model_state_feedback_monitor.sv
// Response-side checker for the state-feedback model: walks the expected matrix shape,
// compares each element against the golden value and reports protocol, stall and error status.
module model_state_feedback_monitor #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 4,
  parameter int unsigned TOLERANCE    = 0,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned ERROR_WIDTH  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_J_IN,
  input  logic                    DATA_OUT_I_ENABLE,
  input  logic                    DATA_OUT_J_ENABLE,
  input  logic [DATA_SIZE-1:0]    DATA_OUT,
  input  logic [DATA_SIZE-1:0]    EXPECTED_IN,
  input  logic                    READY,
  output logic                    DONE,
  output logic                    PASS,
  output logic [ERROR_WIDTH-1:0]  ERROR_COUNT,
  output logic [CONTROL_SIZE-1:0] FIRST_ERROR_I,
  output logic [CONTROL_SIZE-1:0] FIRST_ERROR_J,
  output logic                    PROTOCOL_ERROR,
  output logic                    TIMEOUT_FLAG
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CONTROL_SIZE-1:0] CtrlOne = CONTROL_SIZE'(1);
  localparam logic [ERROR_WIDTH-1:0] ErrOne = ERROR_WIDTH'(1);
  localparam logic [DATA_SIZE:0] TolVal = (DATA_SIZE + 1)'(TOLERANCE);

  typedef enum logic [2:0] {StIdle, StRowWait, StColumn, StEndWait, StFinish} state_e;

  state_e                  state_q, state_d;
  logic [CONTROL_SIZE-1:0] size_i_q, size_i_d, size_j_q, size_j_d;
  logic [CONTROL_SIZE-1:0] i_q, i_d, j_q, j_d;
  logic [CONTROL_SIZE-1:0] first_i_q, first_i_d, first_j_q, first_j_d;
  logic [ERROR_WIDTH-1:0]  err_q, err_d;
  logic                    proto_q, proto_d, to_q, to_d;
  logic [CntW-1:0]         cnt_q, cnt_d;

  logic                    accept, waiting, row_last, col_last, mismatch;
  logic [DATA_SIZE:0]      diff, abs_diff;

  // One extra bit so the difference of two extreme values cannot wrap.
  assign diff     = {DATA_OUT[DATA_SIZE-1], DATA_OUT} - {EXPECTED_IN[DATA_SIZE-1], EXPECTED_IN};
  assign abs_diff = diff[DATA_SIZE] ? -diff : diff;
  assign mismatch = abs_diff > TolVal;

  assign row_last = (i_q == size_i_q - CtrlOne);
  assign col_last = (j_q == size_j_q - CtrlOne);
  assign waiting  = (state_q == StRowWait) || (state_q == StColumn) || (state_q == StEndWait);

  always_comb begin
    state_d   = state_q;
    size_i_d  = size_i_q;
    size_j_d  = size_j_q;
    i_d       = i_q;
    j_d       = j_q;
    first_i_d = first_i_q;
    first_j_d = first_j_q;
    err_d     = err_q;
    proto_d   = proto_q;
    to_d      = to_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;

    unique case (state_q)
      StIdle, StFinish: begin
        if (START) begin
          size_i_d  = SIZE_I_IN;
          size_j_d  = SIZE_J_IN;
          i_d       = '0;
          j_d       = '0;
          first_i_d = '0;
          first_j_d = '0;
          err_d     = '0;
          proto_d   = 1'b0;
          to_d      = 1'b0;
          cnt_d     = '0;
          state_d   = (SIZE_I_IN == '0 || SIZE_J_IN == '0) ? StEndWait : StRowWait;
        end
      end
      StRowWait: begin
        if (READY) begin
          proto_d = 1'b1;
          state_d = StFinish;
        end else if (DATA_OUT_J_ENABLE && DATA_OUT_I_ENABLE) begin
          accept = 1'b1;
          // Single-column rows complete on their first element.
          if (size_j_q == CtrlOne) begin
            if (row_last) state_d = StEndWait;
            else          i_d     = i_q + CtrlOne;
          end else begin
            j_d     = CtrlOne;
            state_d = StColumn;
          end
        end else if (DATA_OUT_J_ENABLE) begin
          proto_d = 1'b1;
        end
      end
      StColumn: begin
        if (READY) begin
          proto_d = 1'b1;
          state_d = StFinish;
        end else if (DATA_OUT_I_ENABLE) begin
          proto_d = 1'b1;
        end else if (DATA_OUT_J_ENABLE) begin
          accept = 1'b1;
          if (col_last) begin
            j_d = '0;
            if (row_last) begin
              state_d = StEndWait;
            end else begin
              i_d     = i_q + CtrlOne;
              state_d = StRowWait;
            end
          end else begin
            j_d = j_q + CtrlOne;
          end
        end
      end
      StEndWait: begin
        if (READY)                  state_d = StFinish;
        else if (DATA_OUT_J_ENABLE) proto_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // READY on the expiry cycle takes priority over the stall flag.
    if (waiting && !READY) begin
      if (accept) begin
        cnt_d = '0;
      end else if (cnt_q == TimeoutLast) begin
        to_d    = 1'b1;
        state_d = StFinish;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end

    if (accept && mismatch) begin
      if (err_q == '0) begin
        first_i_d = i_q;
        first_j_d = j_q;
      end
      if (!(&err_q)) err_d = err_q + ErrOne;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      size_i_q  <= '0;
      size_j_q  <= '0;
      i_q       <= '0;
      j_q       <= '0;
      first_i_q <= '0;
      first_j_q <= '0;
      err_q     <= '0;
      proto_q   <= 1'b0;
      to_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      size_i_q  <= size_i_d;
      size_j_q  <= size_j_d;
      i_q       <= i_d;
      j_q       <= j_d;
      first_i_q <= first_i_d;
      first_j_q <= first_j_d;
      err_q     <= err_d;
      proto_q   <= proto_d;
      to_q      <= to_d;
      cnt_q     <= cnt_d;
    end
  end

  assign DONE           = (state_q == StFinish);
  assign PASS           = DONE && (err_q == '0) && !proto_q && !to_q;
  assign ERROR_COUNT    = err_q;
  assign FIRST_ERROR_I  = first_i_q;
  assign FIRST_ERROR_J  = first_j_q;
  assign PROTOCOL_ERROR = proto_q;
  assign TIMEOUT_FLAG   = to_q;

endmodule

// File: tb/tb_model_state_feedback_monitor.sv
// Directed bench: two monitors (tolerance 0 and 2) share one stimulus stream.
module tb_model_state_feedback_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  size_i = '0, size_j = '0;
  logic        i_en = 1'b0, j_en = 1'b0;
  logic [63:0] data = '0, expv = '0;
  logic        ready = 1'b0;

  logic        done0, pass0, proto0, to0;
  logic [15:0] err0;
  logic [3:0]  fi0, fj0;
  logic        done2, pass2, proto2, to2;
  logic [15:0] err2;
  logic [3:0]  fi2, fj2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  model_state_feedback_monitor #(
    .DATA_SIZE(64), .CONTROL_SIZE(4), .TOLERANCE(0), .TIMEOUT(16), .ERROR_WIDTH(16)
  ) u_dut0 (
    .CLK(clk), .RST(rst_n), .START(start), .SIZE_I_IN(size_i), .SIZE_J_IN(size_j),
    .DATA_OUT_I_ENABLE(i_en), .DATA_OUT_J_ENABLE(j_en), .DATA_OUT(data), .EXPECTED_IN(expv),
    .READY(ready), .DONE(done0), .PASS(pass0), .ERROR_COUNT(err0), .FIRST_ERROR_I(fi0),
    .FIRST_ERROR_J(fj0), .PROTOCOL_ERROR(proto0), .TIMEOUT_FLAG(to0)
  );

  model_state_feedback_monitor #(
    .DATA_SIZE(64), .CONTROL_SIZE(4), .TOLERANCE(2), .TIMEOUT(16), .ERROR_WIDTH(16)
  ) u_dut2 (
    .CLK(clk), .RST(rst_n), .START(start), .SIZE_I_IN(size_i), .SIZE_J_IN(size_j),
    .DATA_OUT_I_ENABLE(i_en), .DATA_OUT_J_ENABLE(j_en), .DATA_OUT(data), .EXPECTED_IN(expv),
    .READY(ready), .DONE(done2), .PASS(pass2), .ERROR_COUNT(err2), .FIRST_ERROR_I(fi2),
    .FIRST_ERROR_J(fj2), .PROTOCOL_ERROR(proto2), .TIMEOUT_FLAG(to2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [3:0] si, input logic [3:0] sj);
    start = 1'b1; size_i = si; size_j = sj;
    tick();
    start = 1'b0;
  endtask

  task automatic elem(input logic ie, input logic [63:0] d, input logic [63:0] e);
    i_en = ie; j_en = 1'b1; data = d; expv = e;
    tick();
    i_en = 1'b0; j_en = 1'b0;
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // Reset
    idle(3);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);
    chk("rst_proto", proto0, 0);
    chk("rst_to", to0, 0);
    chk("rst_first", {fi0, fj0}, 0);
    rst_n = 1'b1;
    idle(2);
    chk("idle_done", done0, 0);

    // 2x3 clean run
    do_start(4'd2, 4'd3);
    elem(1, 64'd10, 64'd10); elem(0, 64'd11, 64'd11); elem(0, 64'd12, 64'd12);
    elem(1, 64'd13, 64'd13); elem(0, 64'd14, 64'd14); elem(0, 64'd15, 64'd15);
    chk("clean_not_done_before_ready", done0, 0);
    pulse_ready();
    chk("clean_done", done0, 1);
    chk("clean_pass", pass0, 1);
    chk("clean_err", err0, 0);
    chk("clean_proto", proto0, 0);
    tick();
    chk("clean_done_held", done0, 1);

    // 2x3 with (1,2)=5 vs 7
    do_start(4'd2, 4'd3);
    chk("restart_done_drops", done0, 0);
    elem(1, 64'd1, 64'd1); elem(0, 64'd2, 64'd2); elem(0, 64'd3, 64'd3);
    elem(1, 64'd4, 64'd4); elem(0, 64'd6, 64'd6); elem(0, 64'd5, 64'd7);
    chk("mm_err_next_edge", err0, 1);
    pulse_ready();
    chk("mm_done", done0, 1);
    chk("mm_err", err0, 1);
    chk("mm_first_i", fi0, 1);
    chk("mm_first_j", fj0, 2);
    chk("mm_pass", pass0, 0);
    chk("mm_tol2_err", err2, 0);
    chk("mm_tol2_pass", pass2, 1);

    // Tolerance / sign handling on a 1x3 row
    do_start(4'd1, 4'd3);
    elem(1, -64'sd3, -64'sd1);
    chk("tol_t0_err_a", err0, 1);
    chk("tol_t2_err_a", err2, 0);
    elem(0, -64'sd4, -64'sd1);
    chk("tol_t2_err_b", err2, 1);
    elem(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    pulse_ready();
    chk("tol_t0_err", err0, 3);
    chk("tol_t0_first", {fi0, fj0}, {4'd0, 4'd0});
    chk("tol_t2_err", err2, 2);
    chk("tol_t2_first", {fi2, fj2}, {4'd0, 4'd1});
    chk("tol_t2_pass", pass2, 0);

    // Row start missing on row 1, then early READY
    do_start(4'd2, 4'd3);
    elem(1, 64'd1, 64'd1); elem(0, 64'd2, 64'd2); elem(0, 64'd3, 64'd3);
    chk("proto_clear_before", proto0, 0);
    elem(0, 64'd4, 64'd4);
    chk("proto_set", proto0, 1);
    chk("proto_not_done", done0, 0);
    pulse_ready();
    chk("proto_done", done0, 1);
    chk("proto_pass", pass0, 0);
    chk("proto_err", err0, 0);

    // Stall: no strobes after START
    do_start(4'd2, 4'd2);
    idle(15);
    chk("to_not_yet_done", done0, 0);
    chk("to_not_yet_flag", to0, 0);
    tick();
    chk("to_done", done0, 1);
    chk("to_flag", to0, 1);
    chk("to_pass", pass0, 0);

    // Reset mid-check, then clean 3x3
    do_start(4'd2, 4'd3);
    elem(1, 64'd1, 64'd1); elem(0, 64'd1, 64'd2); elem(0, 64'd3, 64'd3);
    chk("midrst_err_before", err0, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_err_async", err0, 0);
    chk("midrst_to_async", to0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start(4'd3, 4'd3);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) elem(c == 0, 64'(r * 3 + c), 64'(r * 3 + c));
    end
    pulse_ready();
    chk("post_rst_done", done0, 1);
    chk("post_rst_pass", pass0, 1);
    chk("post_rst_err", err0, 0);
    chk("post_rst_first", {fi0, fj0}, 0);

    // Zero-size matrix: any element is a violation
    do_start(4'd0, 4'd3);
    elem(0, 64'd9, 64'd9);
    chk("zero_proto", proto0, 1);
    pulse_ready();
    chk("zero_done", done0, 1);
    chk("zero_pass", pass0, 0);

    // 1x1: READY on the exact expiry cycle wins over the stall
    do_start(4'd1, 4'd1);
    elem(1, 64'd42, 64'd42);
    idle(15);
    chk("tie_not_done", done0, 0);
    pulse_ready();
    chk("tie_done", done0, 1);
    chk("tie_no_flag", to0, 0);
    chk("tie_pass", pass0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
